// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for a byte-enabled RAM port with busy handshake
module mem_access_ctrl #(
  parameter int RAM_BYTES = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        ram_valid,
  output logic        ram_write,
  output logic [3:0]  ram_byte,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, REQ, ACTIVE, DONE, ABORT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] f3_r;
  logic stall_r, bad_f3, mis, oor, legal;
  logic [3:0] byte_en;
  logic [2:0] size;
  logic [31:0] ext;
  always_comb begin
    byte_en = funct3[1:0] == 2'b00 ? 4'b0001 : funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    size    = funct3[1:0] == 2'b00 ? 3'd1 : funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    bad_f3  = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2]);
    mis     = bad_f3 || (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    oor     = ({1'b0, addr} + 33'(size)) > 33'(RAM_BYTES);
    legal   = !mis && !oor;
    ext     = f3_r == 3'b000 ? {{24{ram_rdata[7]}}, ram_rdata[7:0]} :
              f3_r == 3'b100 ? {24'b0, ram_rdata[7:0]} :
              f3_r == 3'b001 ? {{16{ram_rdata[15]}}, ram_rdata[15:0]} :
              f3_r == 3'b101 ? {16'b0, ram_rdata[15:0]} : ram_rdata;
  end
  // the pipeline must hold in the very cycle a legal request is presented
  assign stall = stall_r | (state == IDLE && req && legal);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_r      <= '0;
      stall_r   <= 1'b0;
      done      <= 1'b0;
      fault     <= 2'b00;
      rdata     <= '0;
      ram_valid <= 1'b0;
      ram_write <= 1'b0;
      ram_byte  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 2'b00;
      case (state)
        IDLE: if (req) begin
          if (mis) fault <= 2'b01;
          else if (oor) fault <= 2'b10;
          else begin
            ram_valid <= 1'b1;
            ram_write <= we;
            ram_byte  <= byte_en;
            ram_addr  <= addr;
            ram_wdata <= wdata;
            f3_r      <= funct3;
            stall_r   <= 1'b1;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: if (ram_busy) begin
          cnt   <= '0;
          state <= ACTIVE;
        end else if (cnt == LAST) begin
          ram_valid <= 1'b0;
          stall_r   <= 1'b0;
          fault     <= 2'b11;
          state     <= ABORT;
        end else cnt <= cnt + 1'b1;
        ACTIVE: if (!ram_busy) begin
          ram_valid <= 1'b0;
          ram_byte  <= '0;
          stall_r   <= 1'b0;
          done      <= 1'b1;
          if (!ram_write) rdata <= ext;
          state <= DONE;
        end else if (cnt == LAST) begin
          ram_valid <= 1'b0;
          stall_r   <= 1'b0;
          fault     <= 2'b11;
          state     <= ABORT;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
